// File: rtl/serial2parallel_if.sv
// Word-side handshake of the serial2parallel deserializer.
// parity_err_o exists only when S2P_PARITY_EN is defined.
interface serial2parallel_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] parallel_o;
    logic             valid_o;
    logic             ready_i;
`ifdef S2P_PARITY_EN
    logic             parity_err_o;
`endif

    modport master (
        output parallel_o,
        output valid_o,
`ifdef S2P_PARITY_EN
        output parity_err_o,
`endif
        input  ready_i
    );

    modport slave (
        input  parallel_o,
        input  valid_o,
`ifdef S2P_PARITY_EN
        input  parity_err_o,
`endif
        output ready_i
    );
endinterface

// File: rtl/serial2parallel.sv
// Serial-to-parallel deserializer with a one-word valid/ready output register.
// Optional S2P_PARITY_EN: each frame carries a trailing even-parity bit.
module serial2parallel #(
    parameter int WIDTH     = 4,
    parameter int LSB_FIRST = 1,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_i,
    input  logic                 valid_i,
    input  logic                 clear_i,
    serial2parallel_if.master    out_if,
    output logic                 busy_o,
    output logic [CW-1:0]        count_o,
    output logic                 overrun_o
);

`ifdef S2P_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int            FRAME = WIDTH + PAR_BITS;
    localparam logic [CW-1:0] LAST  = CW'(FRAME - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] new_word;
    logic [WIDTH-1:0] par_q;
    logic             ovr_q;
    logic             take_bit;
    logic             last_bit;
    logic             complete;
    logic             load;
    logic             drop;
`ifdef S2P_PARITY_EN
    logic             new_err;
    logic             err_q;
`endif

    // Next shifter value and the word formed when a frame completes.
    always_comb begin
        if (LSB_FIRST != 0) begin
            shifted = {serial_i, sr_q[WIDTH-1:1]};
        end else begin
            shifted = {sr_q[WIDTH-2:0], serial_i};
        end
        take_bit = valid_i && !clear_i;
        last_bit = (count_q == LAST);
        complete = take_bit && last_bit;
`ifdef S2P_PARITY_EN
        // Data is already fully shifted in; the final bit is the parity bit.
        new_word = sr_q;
        new_err  = (^sr_q) ^ serial_i;
`else
        new_word = shifted;
`endif
    end

    // Bit counter and shift register; clear beats an incoming bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            sr_q    <= '0;
        end else if (clear_i) begin
            count_q <= '0;
            sr_q    <= '0;
        end else if (take_bit) begin
            if (last_bit) begin
                count_q <= '0;
                sr_q    <= '0;
            end else begin
                count_q <= count_q + CW'(1);
                sr_q    <= shifted;
            end
        end
    end

    // Output register state (EMPTY/FULL) held in a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Load/drop decision and next output-register state.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (complete) begin
                    load    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_if.ready_i) begin
                    load    = complete;
                    state_d = complete ? FULL : EMPTY;
                end else begin
                    drop    = complete;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Word register: only written when a completed word is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= '0;
        end else if (load) begin
            par_q <= new_word;
        end
    end

`ifdef S2P_PARITY_EN
    // Parity error travels with the word it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (load) begin
            err_q <= new_err;
        end
    end

    assign out_if.parity_err_o = err_q;
`endif

    // Sticky overrun; clear has priority over a dropped word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr_q <= 1'b0;
        end else if (clear_i) begin
            ovr_q <= 1'b0;
        end else if (drop) begin
            ovr_q <= 1'b1;
        end
    end

    assign out_if.parallel_o = par_q;
    assign out_if.valid_o    = (state_q == FULL);
    assign busy_o            = (count_q != '0);
    assign count_o           = count_q;
    assign overrun_o         = ovr_q;

endmodule

// File: tb/tb_serial2parallel.sv
// Directed self-checking bench for serial2parallel (WIDTH=4, LSB first).
// Build with +define+S2P_PARITY_EN to exercise the parity frame format.
module tb_serial2parallel;

    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH + 1);

    logic          clk;
    logic          reset;
    logic          serial_i;
    logic          valid_i;
    logic          clear_i;
    logic          busy_o;
    logic [CW-1:0] count_o;
    logic          overrun_o;

    int n_chk;
    int n_fail;

    serial2parallel_if #(.WIDTH(WIDTH)) s_if ();

    serial2parallel #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .serial_i  (serial_i),
        .valid_i   (valid_i),
        .clear_i   (clear_i),
        .out_if    (s_if.master),
        .busy_o    (busy_o),
        .count_o   (count_o),
        .overrun_o (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 after edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic b);
        valid_i  = 1'b1;
        serial_i = b;
        tick();
        valid_i  = 1'b0;
    endtask

    // Parity bit for the frame format in use (even parity, no error).
    task automatic pbit(input logic [WIDTH-1:0] w);
`ifdef S2P_PARITY_EN
        bit_in(^w);
`else
        if (w === 'x) $display("bad word");
`endif
    endtask

    task automatic word_in(input logic [WIDTH-1:0] w);
        for (int i = 0; i < WIDTH; i++) bit_in(w[i]);
        pbit(w);
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        serial_i = 1'b0;
        valid_i  = 1'b0;
        clear_i  = 1'b0;
        s_if.ready_i = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(s_if.valid_o), 0);
        chk("rst_par", 32'(s_if.parallel_o), 0);
        reset = 1'b0;
        tick();

        // Back-to-back 1,0,1,1 with consumer ready
        s_if.ready_i = 1'b1;
        bit_in(1'b1);
        chk("b2b_busy1", 32'(busy_o), 1);
        chk("b2b_cnt1", 32'(count_o), 1);
        bit_in(1'b0);
        chk("b2b_busy2", 32'(busy_o), 1);
        bit_in(1'b1);
        chk("b2b_busy3", 32'(busy_o), 1);
        chk("b2b_cnt3", 32'(count_o), 3);
        bit_in(1'b1);
        pbit(4'hD);
        chk("b2b_valid", 32'(s_if.valid_o), 1);
        chk("b2b_par", 32'(s_if.parallel_o), 32'hD);
        chk("b2b_busy_end", 32'(busy_o), 0);
        chk("b2b_cnt_end", 32'(count_o), 0);
        tick();
        chk("b2b_drain", 32'(s_if.valid_o), 0);

        // Same word with 3 idle cycles between bits
        bit_in(1'b1);
        repeat (3) tick();
        chk("gap_cnt1", 32'(count_o), 1);
        bit_in(1'b0);
        repeat (3) tick();
        chk("gap_cnt2", 32'(count_o), 2);
        bit_in(1'b1);
        repeat (3) tick();
        chk("gap_cnt3", 32'(count_o), 3);
        chk("gap_novalid", 32'(s_if.valid_o), 0);
        bit_in(1'b1);
        pbit(4'hD);
        chk("gap_valid", 32'(s_if.valid_o), 1);
        chk("gap_par", 32'(s_if.parallel_o), 32'hD);
        tick();
        chk("gap_drain", 32'(s_if.valid_o), 0);

        // Overrun: consumer stalled, second word dropped
        s_if.ready_i = 1'b0;
        word_in(4'hD);
        chk("ovr_first_valid", 32'(s_if.valid_o), 1);
        chk("ovr_first_par", 32'(s_if.parallel_o), 32'hD);
        chk("ovr_none_yet", 32'(overrun_o), 0);
        word_in(4'h2);
        chk("ovr_flag", 32'(overrun_o), 1);
        chk("ovr_hold_par", 32'(s_if.parallel_o), 32'hD);
        chk("ovr_hold_valid", 32'(s_if.valid_o), 1);
        s_if.ready_i = 1'b1;
        tick();
        chk("ovr_drain", 32'(s_if.valid_o), 0);
        chk("ovr_sticky", 32'(overrun_o), 1);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("ovr_clear", 32'(overrun_o), 0);

        // clear_i together with valid_i drops the partial word and the bit
        bit_in(1'b1);
        bit_in(1'b1);
        chk("clr_cnt_pre", 32'(count_o), 2);
        clear_i = 1'b1;
        bit_in(1'b1);
        clear_i = 1'b0;
        chk("clr_cnt", 32'(count_o), 0);
        chk("clr_busy", 32'(busy_o), 0);
        word_in(4'h7);
        chk("clr_next_par", 32'(s_if.parallel_o), 32'h7);
        chk("clr_next_valid", 32'(s_if.valid_o), 1);
        tick();

        // Same-cycle drain and refill, no bubble, no overrun
        s_if.ready_i = 1'b0;
        word_in(4'hD);
        chk("rf_first", 32'(s_if.parallel_o), 32'hD);
        bit_in(1'b1);
        bit_in(1'b1);
        bit_in(1'b1);
        s_if.ready_i = 1'b1;
        bit_in(1'b0);
        pbit(4'h7);
        chk("rf_par", 32'(s_if.parallel_o), 32'h7);
        chk("rf_valid", 32'(s_if.valid_o), 1);
        chk("rf_ovr", 32'(overrun_o), 0);
        tick();

        // clear_i on the completing edge: word is discarded
        s_if.ready_i = 1'b0;
        word_in(4'hD);
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b0);
`ifdef S2P_PARITY_EN
        bit_in(1'b0);
`endif
        clear_i = 1'b1;
        bit_in(1'b0);
        clear_i = 1'b0;
        chk("cw_ovr", 32'(overrun_o), 0);
        chk("cw_par", 32'(s_if.parallel_o), 32'hD);
        chk("cw_valid", 32'(s_if.valid_o), 1);
        chk("cw_cnt", 32'(count_o), 0);

`ifdef S2P_PARITY_EN
        // Parity frames: good and bad parity
        s_if.ready_i = 1'b1;
        tick();
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b1);
        chk("p_cnt4", 32'(count_o), 4);
        chk("p_busy4", 32'(busy_o), 1);
        chk("p_novalid", 32'(s_if.valid_o), 0);
        bit_in(1'b1);
        chk("p_ok_valid", 32'(s_if.valid_o), 1);
        chk("p_ok_par", 32'(s_if.parallel_o), 32'hD);
        chk("p_ok_err", 32'(s_if.parity_err_o), 0);
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b1);
        bit_in(1'b0);
        chk("p_bad_par", 32'(s_if.parallel_o), 32'hD);
        chk("p_bad_err", 32'(s_if.parity_err_o), 1);
        s_if.ready_i = 1'b0;
`endif

        // Asynchronous reset mid-word with a word held and overrun set
        word_in(4'h5);
        word_in(4'h6);
        bit_in(1'b1);
        bit_in(1'b1);
        chk("ar_pre_ovr", 32'(overrun_o), 1);
        chk("ar_pre_cnt", 32'(count_o), 2);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_par", 32'(s_if.parallel_o), 0);
        chk("ar_valid", 32'(s_if.valid_o), 0);
        chk("ar_busy", 32'(busy_o), 0);
        chk("ar_cnt", 32'(count_o), 0);
        chk("ar_ovr", 32'(overrun_o), 0);
        tick();
        reset = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
